// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: conditions the raw pins, deserialises 11-bit frames,
// drops break sequences, tags E0-extended codes and queues make codes for MMIO reads.
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          key_rd,
    output logic [7:0]                    key_data,
    output logic                          key_ext,
    output logic                          key_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          fclk, fclk_d;
    logic [FW-1:0] filt_cnt;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic          par;
    logic [TW-1:0] to_cnt;
    logic          byte_ok;
    logic [7:0]    rx_byte;
    logic          brk, ext;

    logic          strobe, stop_bad, timeout_hit, err_event;
    logic          push_req, do_push, do_pop, full, ovf_event;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign strobe      = fclk_d & ~fclk;
    assign stop_bad    = strobe && (state == ST_STOP) && !(dat_s2 && (^{sh, par}));
    assign timeout_hit = (state != ST_IDLE) && !strobe && (to_cnt == TO_LAST);
    assign err_event   = stop_bad | timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            fclk      <= 1'b1;
            fclk_d    <= 1'b1;
            filt_cnt  <= '0;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            sh        <= '0;
            par       <= 1'b0;
            to_cnt    <= '0;
            byte_ok   <= 1'b0;
            rx_byte   <= '0;
            brk       <= 1'b0;
            ext       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            fclk_d <= fclk;

            // Glitch filter: fclk follows only a run of FILTER_LEN differing samples.
            if (clk_s2 != fclk) begin
                if (filt_cnt == FILT_LAST) begin
                    fclk     <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end

            byte_ok <= 1'b0;
            if (state == ST_IDLE) begin
                to_cnt <= '0;
                if (strobe && !dat_s2) begin
                    state   <= ST_DATA;
                    bit_cnt <= '0;
                end
            end else if (strobe) begin
                to_cnt <= '0;
                case (state)
                    ST_DATA: begin
                        sh      <= {dat_s2, sh[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= dat_s2;
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (dat_s2 && (^{sh, par})) begin
                            byte_ok <= 1'b1;
                            rx_byte <= sh;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (to_cnt == TO_LAST) begin
                state   <= ST_IDLE;
                sh      <= '0;
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (byte_ok) begin
                if (rx_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else if (brk) begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else begin
                    ext <= 1'b0;
                end
            end
            // A broken frame leaves any prefix meaningless, so forget it.
            if (err_event) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end

            if (err_event)    frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
        end
    end

    // Read handshake: key_valid means the head entry is presented on key_data/key_ext;
    // a key_rd pulse while key_valid is high consumes it, key_rd while empty is ignored.
    assign push_req  = byte_ok && !brk && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
    assign do_pop    = key_rd && (fifo_count != '0);
    assign full      = (fifo_count == CNT_FULL);
    assign do_push   = push_req && (!full || do_pop);
    assign ovf_event = push_req && full && !do_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {ext, rx_byte};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (ovf_event)    overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
        end
    end

    assign key_data  = mem[rd_ptr][7:0];
    assign key_ext   = mem[rd_ptr][8];
    assign key_valid = (fifo_count != '0);

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: frames are bit-banged on the pins and the
// FIFO head is checked against hand-computed expected entries.
module tb_ps2_keyboard_rx;
    localparam int HALF = 10;
    localparam int TO   = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_rd = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] key_data;
    logic       key_ext;
    logic       key_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overflow;

    ps2_keyboard_rx #(
        .FIFO_DEPTH(4),
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .key_rd(key_rd),
        .key_data(key_data),
        .key_ext(key_ext),
        .key_valid(key_valid),
        .fifo_count(fifo_count),
        .frame_err(frame_err),
        .overflow(overflow),
        .err_clr(err_clr)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [15:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check_eq({tag, "_data"},  16'(key_data), 16'h0);
        check_eq({tag, "_ext"},   16'(key_ext), 16'h0);
        check_eq({tag, "_valid"}, 16'(key_valid), 16'h0);
        check_eq({tag, "_count"}, 16'(fifo_count), 16'h0);
        check_eq({tag, "_ferr"},  16'(frame_err), 16'h0);
        check_eq({tag, "_ovf"},   16'(overflow), 16'h0);
    endtask

    // Drivers
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    function automatic logic [9:0] frame_bits(input logic [7:0] b, input logic bad_par);
        return {(~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_partial(input logic [7:0] b, input int n);
        logic [9:0] bits;
        bits = frame_bits(b, 1'b0);
        for (int i = 0; i < n; i++) ps2_bit(bits[i]);
    endtask

    // mode 0: plain frame; 1: check key_valid latency; 2: pulse key_rd on the push cycle
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int mode);
        logic [9:0] bits;
        bits = frame_bits(b, bad_par);
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        if (mode == 1) begin
            repeat (7) @(posedge clk);
            @(negedge clk);
            check_eq("lat_pre", 16'(key_valid), 16'h0);
            @(posedge clk);
            @(negedge clk);
            check_eq("lat_valid", 16'(key_valid), 16'h1);
        end else if (mode == 2) begin
            repeat (7) @(posedge clk);
            #1 key_rd = 1'b1;
            @(posedge clk);
            #1 key_rd = 1'b0;
        end
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd();
        @(posedge clk);
        #1 key_rd = 1'b1;
        @(posedge clk);
        #1 key_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    // Scoreboard: compare head against the oldest expected entry, then pop it
    task automatic pop_expect(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            @(negedge clk);
            check_eq({tag, "_valid"}, 16'(key_valid), 16'h1);
            check_eq({tag, "_entry"}, {7'd0, key_ext, key_data}, e);
            pulse_rd();
        end
    endtask

    task automatic check_count(input string tag, input int exp);
        @(negedge clk);
        check_eq(tag, 16'(fifo_count), 16'(exp));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("reset");
        repeat (20) @(posedge clk);
        #1;

        // Single make code, exact latency, then pop
        send_frame(8'h1C, 1'b0, 1);
        @(negedge clk);
        check_eq("t1_data", 16'(key_data), 16'h001C);
        check_eq("t1_ext", 16'(key_ext), 16'h0);
        check_count("t1_count", 1);
        pulse_rd();
        @(negedge clk);
        check_eq("t1_popped", 16'(key_valid), 16'h0);

        // Break sequence is discarded
        send_frame(8'h1C, 1'b0, 0);
        send_frame(8'hF0, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 0);
        exp_q.push_back(16'h001C);
        check_count("t2_count", 1);
        check_eq("t2_ferr", 16'(frame_err), 16'h0);
        pop_expect("t2_pop");

        // Extended make kept, extended break dropped, ext flag cleared afterwards
        send_frame(8'hE0, 1'b0, 0);
        send_frame(8'h75, 1'b0, 0);
        send_frame(8'hE0, 1'b0, 0);
        send_frame(8'hF0, 1'b0, 0);
        send_frame(8'h75, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 0);
        exp_q.push_back(16'h0175);
        exp_q.push_back(16'h001C);
        check_count("t3_count", 2);
        pop_expect("t3_pop0");
        pop_expect("t3_pop1");

        // Parity error, clear, recovery
        send_frame(8'h1C, 1'b1, 0);
        check_count("t4_count", 0);
        @(negedge clk);
        check_eq("t4_ferr_set", 16'(frame_err), 16'h1);
        pulse_clr();
        @(negedge clk);
        check_eq("t4_ferr_clr", 16'(frame_err), 16'h0);
        send_frame(8'h29, 1'b0, 0);
        exp_q.push_back(16'h0029);
        pop_expect("t4_pop");

        // Overflow with a full FIFO
        send_frame(8'h16, 1'b0, 0);
        send_frame(8'h1E, 1'b0, 0);
        send_frame(8'h26, 1'b0, 0);
        send_frame(8'h25, 1'b0, 0);
        send_frame(8'h2E, 1'b0, 0);
        check_count("t5_count_full", 4);
        @(negedge clk);
        check_eq("t5_ovf", 16'(overflow), 16'h1);
        exp_q.push_back(16'h0016);
        exp_q.push_back(16'h001E);
        exp_q.push_back(16'h0026);
        exp_q.push_back(16'h0025);
        for (int i = 0; i < 4; i++) pop_expect("t5_pop");
        check_count("t5_count_empty", 0);
        pulse_clr();
        @(negedge clk);
        check_eq("t5_ovf_clr", 16'(overflow), 16'h0);

        // Simultaneous push and pop while full
        send_frame(8'h16, 1'b0, 0);
        send_frame(8'h1E, 1'b0, 0);
        send_frame(8'h26, 1'b0, 0);
        send_frame(8'h25, 1'b0, 0);
        send_frame(8'h2E, 1'b0, 2);
        check_count("t5b_count", 4);
        @(negedge clk);
        check_eq("t5b_ovf", 16'(overflow), 16'h0);
        exp_q.push_back(16'h001E);
        exp_q.push_back(16'h0026);
        exp_q.push_back(16'h0025);
        exp_q.push_back(16'h002E);
        for (int i = 0; i < 4; i++) pop_expect("t5b_pop");

        // Stalled frame times out, then a full frame is accepted
        send_partial(8'h1C, 4);
        repeat (300) @(posedge clk);
        @(negedge clk);
        check_eq("t6_ferr_early", 16'(frame_err), 16'h0);
        repeat (150) @(posedge clk);
        @(negedge clk);
        check_eq("t6_ferr_timeout", 16'(frame_err), 16'h1);
        check_eq("t6_count_empty", 16'(fifo_count), 16'h0);
        #1;
        send_frame(8'h1C, 1'b0, 0);
        check_count("t6_count", 1);
        @(negedge clk);
        check_eq("t6_entry", {7'd0, key_ext, key_data}, 16'h001C);

        // Reset mid-frame clears everything, then receive again
        send_partial(8'h29, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        check_all_zero("midrst");
        repeat (20) @(posedge clk);
        #1;
        send_frame(8'h29, 1'b0, 0);
        exp_q.push_back(16'h0029);
        check_count("t7_count", 1);
        @(negedge clk);
        check_eq("t7_ferr", 16'(frame_err), 16'h0);
        pop_expect("t7_pop");

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
